// File: rtl/rvm_mem_ctrl_pkg.sv
// rvm_mem_ctrl_pkg: shared access-size codes and controller state encodings.
package rvm_mem_ctrl_pkg;

    localparam logic [1:0] RVM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] RVM_SIZE_HALF = 2'b01;
    localparam logic [1:0] RVM_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        RVM_MEMC_IDLE = 2'd0,
        RVM_MEMC_REQ  = 2'd1,
        RVM_MEMC_RESP = 2'd2
    } memc_state_e;

endpackage

// File: rtl/rvm_lsu_align.sv
// rvm_lsu_align: byte-lane strobes, store replication, load extraction/extension
// and misalignment detection for one access size and address offset.
module rvm_lsu_align
    import rvm_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] sh;

    // size 2'b11 falls through every comparison and behaves as a word
    always_comb begin
        sh         = rdata >> {off, 3'b000};
        strb       = size == RVM_SIZE_BYTE ? 4'b0001 << off :
                     size == RVM_SIZE_HALF ? 4'b0011 << off : 4'hF;
        wdata_rep  = size == RVM_SIZE_BYTE ? {4{wdata[7:0]}} :
                     size == RVM_SIZE_HALF ? {2{wdata[15:0]}} : wdata;
        rdata_ext  = size == RVM_SIZE_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
                     size == RVM_SIZE_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
        misaligned = size == RVM_SIZE_BYTE ? 1'b0 :
                     size == RVM_SIZE_HALF ? off[0] : |off;
    end

endmodule

// File: rtl/rvm_mem_ctrl.sv
// rvm_mem_ctrl: single-port fetch/load/store controller driving a req/gnt/rvalid bus,
// one request in flight at a time, with timeout and misalignment errors.
module rvm_mem_ctrl
    import rvm_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    input  logic        ls_req,
    input  logic        ls_wen,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        busy,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic        mem_error,
    output logic        bus_req,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_strb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    input  logic        bus_err
);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    memc_state_e state_q, state_d;
    logic        is_fetch_q, is_fetch_d, wen_q, wen_d, sgn_q, sgn_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] mem_rdata_q, mem_rdata_d, ls_rdata_q, ls_rdata_d;
    logic        mem_valid_q, mem_valid_d, ls_done_q, ls_done_d, mem_error_q, mem_error_d;
    logic        idle, is_store;
    logic [1:0]  a_size, a_off;
    logic [3:0]  a_strb;
    logic [31:0] a_wdata, a_rdata;
    logic        a_mis;

    // In IDLE the aligner checks the incoming request; afterwards it decodes the latched one.
    assign idle     = state_q == RVM_MEMC_IDLE;
    assign is_store = ls_req & ls_wen;
    assign a_size   = idle ? (ls_req ? ls_size : RVM_SIZE_WORD) : size_q;
    assign a_off    = idle ? (ls_req ? ls_addr[1:0] : fetch_addr[1:0]) : addr_q[1:0];

    rvm_lsu_align u_align (
        .size       (a_size),
        .off        (a_off),
        .sgn        (sgn_q),
        .wdata      (ls_wdata),
        .rdata      (bus_rdata),
        .strb       (a_strb),
        .wdata_rep  (a_wdata),
        .rdata_ext  (a_rdata),
        .misaligned (a_mis)
    );

    always_comb begin
        state_d     = state_q;
        is_fetch_d  = is_fetch_q;
        wen_d       = wen_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        tmo_d       = tmo_q + 1'b1;
        mem_rdata_d = mem_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_valid_d = 1'b0;
        ls_done_d   = 1'b0;
        mem_error_d = 1'b0;
        case (state_q)
            RVM_MEMC_IDLE: begin
                tmo_d = '0;
                if (ls_req || fetch_req) begin
                    if (a_mis) begin
                        mem_error_d = 1'b1;
                    end else begin
                        state_d    = RVM_MEMC_REQ;
                        is_fetch_d = !ls_req;
                        wen_d      = is_store;
                        sgn_d      = ls_signed;
                        size_d     = ls_req ? ls_size : RVM_SIZE_WORD;
                        addr_d     = ls_req ? ls_addr : fetch_addr;
                        strb_d     = is_store ? a_strb : 4'hF;
                        wdata_d    = is_store ? a_wdata : '0;
                    end
                end
            end
            RVM_MEMC_REQ: begin
                if (bus_gnt) begin
                    state_d = RVM_MEMC_RESP;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = RVM_MEMC_IDLE;
                    mem_error_d = 1'b1;
                end
            end
            RVM_MEMC_RESP: begin
                if (bus_rvalid) begin
                    state_d = RVM_MEMC_IDLE;
                    if (bus_err) begin
                        mem_error_d = 1'b1;
                    end else if (is_fetch_q) begin
                        mem_rdata_d = bus_rdata;
                        mem_valid_d = 1'b1;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = wen_q ? ls_rdata_q : a_rdata;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = RVM_MEMC_IDLE;
                    mem_error_d = 1'b1;
                end
            end
            default: state_d = RVM_MEMC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RVM_MEMC_IDLE;
            is_fetch_q  <= 1'b0;
            wen_q       <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            tmo_q       <= '0;
            mem_rdata_q <= '0;
            ls_rdata_q  <= '0;
            mem_valid_q <= 1'b0;
            ls_done_q   <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_fetch_q  <= is_fetch_d;
            wen_q       <= wen_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            tmo_q       <= tmo_d;
            mem_rdata_q <= mem_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_valid_q <= mem_valid_d;
            ls_done_q   <= ls_done_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign busy      = !idle;
    assign bus_req   = state_q == RVM_MEMC_REQ;
    assign bus_wen   = busy & wen_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_strb  = busy ? strb_q : 4'h0;
    assign bus_wdata = busy ? wdata_q : 32'h0;
    assign mem_rdata = mem_rdata_q;
    assign mem_valid = mem_valid_q;
    assign ls_rdata  = ls_rdata_q;
    assign ls_done   = ls_done_q;
    assign mem_error = mem_error_q;

    a_no_req_while_busy: assert property (@(posedge clk) disable iff (reset) busy |-> !(fetch_req || ls_req));

endmodule

// File: tb/tb_rvm_mem_ctrl.sv
// tb_rvm_mem_ctrl: directed vectors for fetch, aligned loads/stores, misalignment,
// timeout, bus error, request priority and reset during a transaction.
module tb_rvm_mem_ctrl;

    logic        clk = 1'b0, reset = 1'b1;
    logic        fetch_req = 1'b0, ls_req = 1'b0, ls_wen = 1'b0, ls_signed = 1'b0;
    logic [31:0] fetch_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [1:0]  ls_size = '0;
    logic        busy, mem_valid, ls_done, mem_error, bus_req, bus_wen;
    logic [31:0] mem_rdata, ls_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_strb;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    int n_vec = 0, n_miss = 0;
    logic        s_busy, s_req, s_wen, s_req2, p_valid, p_done, p_err, q_any;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;

    rvm_mem_ctrl dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_size(ls_size), .ls_signed(ls_signed),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .busy(busy), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .ls_rdata(ls_rdata), .ls_done(ls_done), .mem_error(mem_error),
        .bus_req(bus_req), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_strb(bus_strb), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_fetch(input logic [31:0] a);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
    endtask

    task automatic start_ls(input logic wen, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        ls_req    = 1'b1;
        ls_wen    = wen;
        ls_size   = sz;
        ls_signed = sg;
        ls_addr   = a;
        ls_wdata  = wd;
    endtask

    // Bus responder: gnt after gd REQ cycles, rvalid the cycle after gnt; snapshots outputs.
    task automatic xfer(input int gd, input logic [31:0] rd, input logic er);
        @(negedge clk);
        fetch_req = 1'b0;
        ls_req    = 1'b0;
        s_busy  = busy;
        s_req   = bus_req;
        s_addr  = bus_addr;
        s_strb  = bus_strb;
        s_wdata = bus_wdata;
        s_wen   = bus_wen;
        repeat (gd) @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        bus_err    = er;
        s_req2     = bus_req;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        p_valid = mem_valid;
        p_done  = ls_done;
        p_err   = mem_error;
        @(negedge clk);
        q_any = mem_valid | ls_done | mem_error;
    endtask

    task automatic misaligned(input string tag);
        @(negedge clk);
        fetch_req = 1'b0;
        ls_req    = 1'b0;
        chk({tag, "_err"}, mem_error, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_breq"}, bus_req, 0);
        @(negedge clk);
        chk({tag, "_err_once"}, mem_error, 0);
        chk({tag, "_breq2"}, bus_req, 0);
    endtask

    initial begin
        int n;
        logic acc;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {mem_valid, ls_done, mem_error}, 0);
        chk("rst_bus", {bus_req, bus_wen, bus_strb}, 0);
        chk("rst_baddr", bus_addr, 0);
        chk("rst_bwdata", bus_wdata, 0);
        chk("rst_memrd", mem_rdata, 0);
        chk("rst_lsrd", ls_rdata, 0);
        reset = 1'b0;

        start_fetch(32'h100);
        xfer(2, 32'h0050_0093, 1'b0);
        chk("f_busy", s_busy, 1);
        chk("f_req", s_req, 1);
        chk("f_addr", s_addr, 32'h100);
        chk("f_strb", s_strb, 4'hF);
        chk("f_wen", s_wen, 0);
        chk("f_req_drop", s_req2, 0);
        chk("f_valid", p_valid, 1);
        chk("f_done", p_done, 0);
        chk("f_rdata", mem_rdata, 32'h0050_0093);
        chk("f_once", q_any, 0);

        start_ls(1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
        xfer(0, 32'h8012_3456, 1'b0);
        chk("lbs_addr", s_addr, 32'h200);
        chk("lbs_strb", s_strb, 4'hF);
        chk("lbs_wen", s_wen, 0);
        chk("lbs_done", p_done, 1);
        chk("lbs_data", ls_rdata, 32'hFFFF_FF80);
        chk("lbs_once", q_any, 0);
        start_ls(1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
        xfer(1, 32'h8012_3456, 1'b0);
        chk("lbu_data", ls_rdata, 32'h0000_0080);
        start_ls(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        xfer(0, 32'h8001_7FFF, 1'b0);
        chk("lhs_data", ls_rdata, 32'hFFFF_8001);
        start_ls(1'b0, 2'b00, 1'b0, 32'h201, 32'h0);
        xfer(0, 32'h0000_A500, 1'b0);
        chk("lbu1_data", ls_rdata, 32'h0000_00A5);
        chk("f_rdata_hold", mem_rdata, 32'h0050_0093);

        start_ls(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD);
        xfer(1, 32'h0, 1'b0);
        chk("sh_addr", s_addr, 32'h100);
        chk("sh_strb", s_strb, 4'b1100);
        chk("sh_wdata", s_wdata, 32'hABCD_ABCD);
        chk("sh_wen", s_wen, 1);
        chk("sh_done", p_done, 1);
        chk("sh_lsrd_hold", ls_rdata, 32'h0000_00A5);
        start_ls(1'b1, 2'b00, 1'b0, 32'h201, 32'hDEAD_BE77);
        xfer(0, 32'h0, 1'b0);
        chk("sb_strb", s_strb, 4'b0010);
        chk("sb_wdata", s_wdata, 32'h7777_7777);
        start_ls(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFE_F00D);
        xfer(0, 32'h0, 1'b0);
        chk("sw_strb", s_strb, 4'hF);
        chk("sw_wdata", s_wdata, 32'hCAFE_F00D);

        start_ls(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        misaligned("mis_lw");
        start_ls(1'b0, 2'b01, 1'b0, 32'h105, 32'h0);
        misaligned("mis_lh");
        start_fetch(32'h102);
        misaligned("mis_f");

        start_fetch(32'h300);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        n = 1;
        while (!mem_error && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_cycles", n, 256);
        chk("tmo_idle", {busy, bus_req}, 0);
        chk("tmo_rdata_hold", mem_rdata, 32'h0050_0093);

        start_fetch(32'h104);
        xfer(0, 32'hDEAD_BEEF, 1'b1);
        chk("berr_err", p_err, 1);
        chk("berr_valid", p_valid, 0);
        chk("berr_rdata", mem_rdata, 32'h0050_0093);

        @(negedge clk);
        ls_req = 1'b1; ls_wen = 1'b0; ls_size = 2'b10; ls_signed = 1'b0; ls_addr = 32'h400;
        fetch_req = 1'b1; fetch_addr = 32'h500;
        xfer(0, 32'h1357_9BDF, 1'b0);
        chk("prio_addr", s_addr, 32'h400);
        chk("prio_done", p_done, 1);
        chk("prio_valid", p_valid, 0);
        chk("prio_lsrd", ls_rdata, 32'h1357_9BDF);
        chk("prio_memrd", mem_rdata, 32'h0050_0093);

        start_fetch(32'h600);
        @(negedge clk);
        fetch_req = 1'b0;
        bus_gnt   = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rr_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rr_busy0", busy, 0);
        chk("rr_bus0", {bus_req, bus_wen, bus_strb}, 0);
        chk("rr_baddr0", bus_addr, 0);
        chk("rr_memrd0", mem_rdata, 0);
        chk("rr_lsrd0", ls_rdata, 0);
        @(negedge clk);
        reset      = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hFFFF_FFFF;
        acc = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            acc |= mem_valid | ls_done | mem_error | busy;
        end
        chk("rr_no_pulse", acc, 0);
        chk("rr_memrd_after", mem_rdata, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
